// File: rtl/alu_pkg.sv
// Shared types for the ALU operation sequencer: op codes, FSM states, default width.
package alu_pkg;

  localparam int unsigned ALU_W = 3;

  typedef enum logic [1:0] {
    OP_SUM = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_seq_timer.sv
// Clearable saturating RUN-cycle counter with compare flags for the fast-unit
// latency and the slow-unit timeout.
module alu_seq_timer #(
  parameter int unsigned CW       = 5,
  parameter int unsigned LAT_FAST = 1,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic lat_hit,
  output logic tmo_hit
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CW{1'b1}})) begin
      cnt_d = CW'(cnt_q + 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Timeout fires at the end of the TIMEOUT-th RUN cycle (count starts at 0).
  assign lat_hit = (cnt_q == CW'(LAT_FAST));
  assign tmo_hit = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequencer that latches one ALU request, drives the selected unit's Init and
// captures its result. Optional mul/div abort enabled by ALU_SEQ_TIMEOUT_EN.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned W        = ALU_W,
  parameter int unsigned LAT_FAST = 1,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           Start,
  input  logic [1:0]     OpSel,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  output logic [3:0]     UnitInit,
  output logic [W-1:0]   UnitA,
  output logic [W-1:0]   UnitB,
  input  logic [W-1:0]   SumRes,
  input  logic           SumErr,
  input  logic [W-1:0]   SubRes,
  input  logic           SubErr,
  input  logic [2*W-1:0] MulRes,
  input  logic           MulDone,
  input  logic [W-1:0]   DivRes,
  input  logic           DivDone,
  output logic           Busy,
  output logic           Valid,
  output logic [2*W-1:0] Result,
  output logic           Error
);

  localparam int unsigned RW   = 2 * W;
  localparam int unsigned MAXV = (LAT_FAST > TIMEOUT) ? LAT_FAST : TIMEOUT;
  localparam int unsigned CW   = $clog2(MAXV + 1);

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [RW-1:0] result_q, result_d;
  logic          error_q, error_d;
  logic          cnt_clr, cnt_inc, lat_hit, tmo_hit;

  alu_seq_timer #(
    .CW       (CW),
    .LAT_FAST (LAT_FAST),
    .TIMEOUT  (TIMEOUT)
  ) u_timer (
    .clk     (Clock),
    .rst     (Reset),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .lat_hit (lat_hit),
    .tmo_hit (tmo_hit)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    error_d  = error_q;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    UnitInit = 4'b0000;
    Busy     = 1'b0;
    Valid    = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        Valid = (state_q == DONE);
        if (Start) begin
          op_d    = op_e'(OpSel);
          a_d     = A;
          b_d     = B;
          cnt_clr = 1'b1;
          // Divide by zero never reaches the unit.
          if ((op_e'(OpSel) == OP_DIV) && (B == '0)) begin
            state_d  = DONE;
            result_d = '0;
            error_d  = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        Busy     = 1'b1;
        cnt_inc  = 1'b1;
        UnitInit = 4'b0001 << op_q;
        case (op_q)
          OP_SUM: if (lat_hit) begin
            result_d = RW'(SumRes);
            error_d  = SumErr;
            state_d  = DONE;
          end
          OP_SUB: if (lat_hit) begin
            result_d = RW'(SubRes);
            error_d  = SubErr;
            state_d  = DONE;
          end
          OP_MUL: if (MulDone) begin
            result_d = MulRes;
            error_d  = 1'b0;
            state_d  = DONE;
          end else if (TMO_EN && tmo_hit) begin
            result_d = '0;
            error_d  = 1'b1;
            state_d  = DONE;
          end
          OP_DIV: if (DivDone) begin
            result_d = RW'(DivRes);
            error_d  = 1'b0;
            state_d  = DONE;
          end else if (TMO_EN && tmo_hit) begin
            result_d = '0;
            error_d  = 1'b1;
            state_d  = DONE;
          end
        endcase
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= IDLE;
      op_q     <= OP_SUM;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      error_q  <= error_d;
    end
  end

  assign UnitA  = a_q;
  assign UnitB  = b_q;
  assign Result = result_q;
  assign Error  = error_q;

endmodule
